// File: rtl/nbit_pipe_register.sv
// Parametrised chain of DEPTH N-bit register stages with valid/ready handshakes,
// full throughput, backpressure, synchronous flush and an occupancy count.
module nbit_pipe_register #(
  parameter int N     = 8,
  parameter int DEPTH = 2,
  parameter int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [N-1:0]     s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [N-1:0]     m_data,
  input  logic             flush,
  output logic [OCC_W-1:0] occupancy
);

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] v_next;
  logic [DEPTH-1:0] load;
  logic [DEPTH-1:0] src_v;
  logic [DEPTH:0]   r;
  logic [N-1:0]     d     [DEPTH];
  logic [N-1:0]     src_d [DEPTH];
  logic [OCC_W-1:0] occ_next;

  // Stage 0 is fed from the upstream port, every later stage from its predecessor.
  for (genvar i = 0; i < DEPTH; i++) begin : g_src
    if (i == 0) begin : g_head
      assign src_v[i] = s_valid;
      assign src_d[i] = s_data;
    end else begin : g_body
      assign src_v[i] = v[i-1];
      assign src_d[i] = d[i-1];
    end
  end

  // Ready ripples back from m_ready; a stage can take a word if it is empty or
  // everything ahead of it is moving. The accumulator keeps r free of self-loops.
  always_comb begin
    logic acc;
    acc      = m_ready;
    r[DEPTH] = m_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      acc  = acc | ~v[i];
      r[i] = acc;
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    v_next = v;
    load   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!flush && r[i]) begin
        v_next[i] = src_v[i];
        load[i]   = src_v[i];
      end
    end
    if (flush) v_next = '0;
  end

  // Occupancy is registered alongside v, so it is computed from next-state valids.
  always_comb begin
    occ_next = '0;
    for (int i = 0; i < DEPTH; i++) occ_next = occ_next + OCC_W'(v_next[i]);
  end

  // NOTE: sequential state uses non-blocking assignments so all stages update together.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      v         <= '0;
      occupancy <= '0;
    end else begin
      v         <= v_next;
      occupancy <= occ_next;
    end
  end

  // NOTE: the data registers are reset too, so m_data reads 0 straight out of reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) d[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (load[i]) d[i] <= src_d[i];
      end
    end
  end

  assign s_ready = r[0] & ~flush;
  assign m_valid = v[DEPTH-1];
  assign m_data  = d[DEPTH-1];

endmodule

// File: tb/tb_nbit_pipe_register.sv
// Self-checking bench for nbit_pipe_register: directed scenarios plus a random
// run checked against a word-queue / occupancy-count reference model.
module tb_nbit_pipe_register;
  localparam int N     = 8;
  localparam int DEPTH = 2;
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [N-1:0]     s_data = '0;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic [N-1:0]     m_data;
  logic             flush = 1'b0;
  logic [OCC_W-1:0] occupancy;

  int vectors     = 0;
  int miscompares = 0;

  nbit_pipe_register #(.N(N), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .flush(flush), .occupancy(occupancy)
  );

  always #5 CLK = ~CLK;

  // Inputs change just after a rising edge; outputs are sampled on the falling edge.
  task automatic next_edge();
    @(posedge CLK);
    #1;
  endtask

  task automatic drain();
    s_valid = 1'b0;
    flush   = 1'b0;
    m_ready = 1'b1;
    repeat (DEPTH + 2) next_edge();
  endtask

  task automatic test_reset();
    #2;
    vectors += 3;
    if (m_valid !== 1'b0) begin miscompares++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
    if (m_data !== 8'h00) begin miscompares++; $display("FAIL reset_m_data: got %h want 00", m_data); end
    if (occupancy !== 0) begin miscompares++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
    next_edge();
    RST = 1'b0;
    m_ready = 1'b0;
    s_valid = 1'b1; s_data = 8'hAA; next_edge();
    s_data = 8'hBB; next_edge();
    s_valid = 1'b0;
    @(negedge CLK);
    vectors++;
    if (occupancy !== 2) begin miscompares++; $display("FAIL reset_fill_occ: got %0d want 2", occupancy); end
    #2 RST = 1'b1;
    #1;
    vectors += 3;
    if (m_valid !== 1'b0) begin miscompares++; $display("FAIL midreset_m_valid: got %b want 0", m_valid); end
    if (m_data !== 8'h00) begin miscompares++; $display("FAIL midreset_m_data: got %h want 00", m_data); end
    if (occupancy !== 0) begin miscompares++; $display("FAIL midreset_occ: got %0d want 0", occupancy); end
    #1 RST = 1'b0;
    next_edge();
    vectors += 2;
    if (s_ready !== 1'b1) begin miscompares++; $display("FAIL release_s_ready: got %b want 1", s_ready); end
    if (m_valid !== 1'b0) begin miscompares++; $display("FAIL release_m_valid: got %b want 0", m_valid); end
  endtask

  task automatic test_latency();
    m_ready = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'hA5;
    @(negedge CLK);
    vectors++;
    if (s_ready !== 1'b1) begin miscompares++; $display("FAIL latency_s_ready: got %b want 1", s_ready); end
    next_edge();  // accepting edge = cycle 1
    s_valid = 1'b0;
    s_data  = 8'h00;
    for (int k = 1; k <= DEPTH + 2; k++) begin
      vectors++;
      if (m_valid !== (k == DEPTH)) begin
        miscompares++;
        $display("FAIL latency_m_valid cycle %0d: got %b want %b", k, m_valid, (k == DEPTH));
      end
      if (k == DEPTH) begin
        vectors++;
        if (m_data !== 8'hA5) begin miscompares++; $display("FAIL latency_m_data: got %h want a5", m_data); end
      end
      next_edge();
    end
  endtask

  task automatic test_streaming();
    logic [N-1:0] got [$];
    int           got_cyc [$];
    m_ready = 1'b1;
    for (int i = 0; i < 16 + DEPTH + 2; i++) begin
      s_valid = (i < 16);
      s_data  = (i < 16) ? N'(i + 1) : '0;
      @(negedge CLK);
      if (i >= DEPTH && i <= 16) begin
        vectors++;
        if (occupancy !== DEPTH) begin
          miscompares++;
          $display("FAIL stream_occ cycle %0d: got %0d want %0d", i, occupancy, DEPTH);
        end
      end
      if (m_valid && m_ready) begin
        got.push_back(m_data);
        got_cyc.push_back(i);
      end
      next_edge();
    end
    s_valid = 1'b0;
    vectors++;
    if (got.size() != 16) begin
      miscompares++;
      $display("FAIL stream_count: got %0d want 16", got.size());
    end else begin
      for (int j = 0; j < 16; j++) begin
        vectors++;
        if (got[j] !== N'(j + 1) || got_cyc[j] != j + DEPTH) begin
          miscompares++;
          $display("FAIL stream_word %0d: got %h at cycle %0d want %h at cycle %0d",
                   j, got[j], got_cyc[j], N'(j + 1), j + DEPTH);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [N-1:0] words [3];
    logic [N-1:0] got [$];
    int           sent;
    words = '{8'h11, 8'h22, 8'h33};
    sent  = 0;
    m_ready = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (c == 6) m_ready = 1'b1;
      s_valid = (sent < 3);
      if (sent < 3) s_data = words[sent];
      @(negedge CLK);
      if (c == 5) begin
        vectors += 3;
        if (occupancy !== DEPTH) begin miscompares++; $display("FAIL bp_occ: got %0d want %0d", occupancy, DEPTH); end
        if (s_ready !== 1'b0) begin miscompares++; $display("FAIL bp_s_ready: got %b want 0", s_ready); end
        if (sent != 2) begin miscompares++; $display("FAIL bp_pending: accepted %0d want 2", sent); end
      end
      if (s_valid && s_ready) sent++;
      if (m_valid && m_ready) got.push_back(m_data);
      next_edge();
    end
    s_valid = 1'b0;
    vectors++;
    if (got.size() != 3) begin
      miscompares++;
      $display("FAIL bp_count: got %0d want 3", got.size());
    end else begin
      for (int j = 0; j < 3; j++) begin
        vectors++;
        if (got[j] !== words[j]) begin
          miscompares++;
          $display("FAIL bp_word %0d: got %h want %h", j, got[j], words[j]);
        end
      end
    end
  endtask

  task automatic test_back_to_back_full();
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_data = 8'h40; next_edge();
    s_data = 8'h41; next_edge();
    for (int k = 0; k < 3; k++) begin
      m_ready = 1'b1;
      s_data  = N'(8'h42 + k);
      @(negedge CLK);
      vectors += 4;
      if (s_ready !== 1'b1) begin miscompares++; $display("FAIL full_s_ready %0d: got %b want 1", k, s_ready); end
      if (m_valid !== 1'b1) begin miscompares++; $display("FAIL full_m_valid %0d: got %b want 1", k, m_valid); end
      if (m_data !== N'(8'h40 + k)) begin
        miscompares++; $display("FAIL full_m_data %0d: got %h want %h", k, m_data, N'(8'h40 + k));
      end
      if (occupancy !== DEPTH) begin miscompares++; $display("FAIL full_occ %0d: got %0d want %0d", k, occupancy, DEPTH); end
      next_edge();
    end
    s_valid = 1'b0;
    m_ready = 1'b0;
    @(negedge CLK);
    vectors += 2;
    if (occupancy !== DEPTH) begin miscompares++; $display("FAIL full_after_occ: got %0d want %0d", occupancy, DEPTH); end
    if (m_data !== 8'h43) begin miscompares++; $display("FAIL full_after_data: got %h want 43", m_data); end
    drain();
  endtask

  task automatic test_flush();
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_data = 8'h50; next_edge();
    s_data = 8'h51; next_edge();
    flush  = 1'b1;
    s_data = 8'hFF;
    @(negedge CLK);
    vectors++;
    if (s_ready !== 1'b0) begin miscompares++; $display("FAIL flush_s_ready: got %b want 0", s_ready); end
    next_edge();
    flush   = 1'b0;
    s_valid = 1'b0;
    vectors += 2;
    if (occupancy !== 0) begin miscompares++; $display("FAIL flush_occ: got %0d want 0", occupancy); end
    if (m_valid !== 1'b0) begin miscompares++; $display("FAIL flush_m_valid: got %b want 0", m_valid); end
    m_ready = 1'b1;
    for (int k = 0; k < DEPTH + 3; k++) begin
      @(negedge CLK);
      vectors++;
      if (m_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL flush_leak cycle %0d: m_valid=%b m_data=%h want no output", k, m_valid, m_data);
      end
      next_edge();
    end
  endtask

  // Reference model: the pipe is an ordered queue of words plus a word count;
  // the block can accept whenever a slot is free or the head is leaving.
  task automatic test_random();
    logic [N-1:0] q [$];
    int           cnt;
    logic         in_x, out_x, exp_ready;
    cnt = 0;
    for (int c = 0; c < 600; c++) begin
      s_valid = ($urandom_range(0, 3) != 0);
      s_data  = N'($urandom);
      m_ready = ($urandom_range(0, 2) != 0);
      flush   = ($urandom_range(0, 24) == 0);
      @(negedge CLK);
      exp_ready = !flush && (cnt < DEPTH || m_ready);
      vectors += 2;
      if (occupancy !== OCC_W'(cnt)) begin
        miscompares++; $display("FAIL rand_occ cycle %0d: got %0d want %0d", c, occupancy, cnt);
      end
      if (s_ready !== exp_ready) begin
        miscompares++; $display("FAIL rand_s_ready cycle %0d: got %b want %b", c, s_ready, exp_ready);
      end
      in_x  = s_valid && s_ready;
      out_x = m_valid && m_ready;
      if (m_valid) begin
        vectors++;
        if (q.size() == 0) begin
          miscompares++; $display("FAIL rand_spurious cycle %0d: m_valid=1 with data %h, model empty", c, m_data);
        end else if (m_data !== q[0]) begin
          miscompares++; $display("FAIL rand_data cycle %0d: got %h want %h", c, m_data, q[0]);
        end
      end
      if (flush) begin
        q.delete();
        cnt = 0;
      end else begin
        if (out_x && q.size() > 0) void'(q.pop_front());
        if (in_x) q.push_back(s_data);
        cnt = q.size();
      end
      next_edge();
    end
    s_valid = 1'b0;
    flush   = 1'b0;
    m_ready = 1'b1;
    for (int c = 0; c < DEPTH + 4; c++) begin
      @(negedge CLK);
      if (m_valid) begin
        vectors++;
        if (q.size() == 0 || m_data !== q[0]) begin
          miscompares++; $display("FAIL rand_drain_data: got %h, model size %0d", m_data, q.size());
        end
        if (q.size() > 0) void'(q.pop_front());
      end
      next_edge();
    end
    vectors++;
    if (q.size() != 0) begin
      miscompares++; $display("FAIL rand_lost: %0d words never emerged", q.size());
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_streaming();
    test_backpressure();
    test_back_to_back_full();
    test_flush();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
